// File: rtl/first_countdown_pkg.sv
// Shared definitions for the loadable down-counter: state encoding and default width.
package first_countdown_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/first_countdown.sv
// Loadable down-counter with terminal-count pulse, sticky underflow flag and
// optional auto-reload, usable as a one-shot timer or a periodic tick source.
//
// state | meaning
// IDLE  | after reset; counter holds, enable ignored, waits for load
// RUN   | decrements on enable; underflow event when enabled at count 0
// DONE  | one-shot finished; counter holds 0, waits for load
module first_countdown
   import first_countdown_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             auto_reload,
   input  logic             clear_underflow,
   output logic [WIDTH-1:0] counter_out,
   output logic             zero_pulse,
   output logic             underflow_out,
   output logic             busy
);

   state_t           state_q;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] reload_q;
   logic             busy_q;
   logic             pulse_q;
   logic             uflag_q;
   logic             uflow_d;

   // A load in the same cycle wins and swallows the event.
   assign uflow_d = (state_q == RUN) && !load && enable && (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         busy_q   <= 1'b0;
      end else if (load) begin
         state_q  <= RUN;
         cnt_q    <= load_value;
         reload_q <= load_value;
         busy_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
            end
            RUN: begin
               if (enable) begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - 1'b1;
                  end else if (auto_reload) begin
                     cnt_q <= reload_q;
                  end else begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            DONE: begin
               cnt_q  <= '0;
               busy_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Setting the sticky flag takes precedence over a coincident clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         pulse_q <= 1'b0;
         uflag_q <= 1'b0;
      end else begin
         pulse_q <= uflow_d;
         uflag_q <= uflow_d | (uflag_q & ~clear_underflow);
      end
   end

   assign counter_out   = cnt_q;
   assign zero_pulse    = pulse_q;
   assign underflow_out = uflag_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_first_countdown.sv
// Scoreboard bench for first_countdown: directed scenarios followed by random
// traffic, each cycle's expected outputs predicted by a cycle-level timer model.
module tb_first_countdown;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_value = '0;
   logic         auto_reload = 1'b0;
   logic         clear_underflow = 1'b0;
   logic [W-1:0] counter_out;
   logic         zero_pulse;
   logic         underflow_out;
   logic         busy;

   first_countdown #(.WIDTH(W)) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .load            (load),
      .load_value      (load_value),
      .auto_reload     (auto_reload),
      .clear_underflow (clear_underflow),
      .counter_out     (counter_out),
      .zero_pulse      (zero_pulse),
      .underflow_out   (underflow_out),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cnt;
      logic pulse;
      logic flag;
      logic busy;
      int   id;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_issued = 0;

   // Timer model: "running" means a run is active; count is an integer that
   // never goes below zero; reaching an enabled cycle at zero is the event.
   bit m_running = 0;
   int m_count = 0;
   int m_period = 0;
   bit m_flag = 0;

   task automatic step(input bit en, input bit ld, input int lv, input bit ar,
                       input bit clr, input bit rst);
      exp_t e;
      bit   ev;
      @(negedge clk);
      enable          = en;
      load            = ld;
      load_value      = W'(lv);
      auto_reload     = ar;
      clear_underflow = clr;
      reset           = rst;
      ev = 0;
      if (rst) begin
         m_running = 0;
         m_count   = 0;
         m_period  = 0;
         m_flag    = 0;
      end else begin
         if (ld) begin
            m_running = 1;
            m_count   = lv % (1 << W);
            m_period  = m_count;
         end else if (m_running && en) begin
            if (m_count > 0) m_count = m_count - 1;
            else begin
               ev = 1;
               if (ar) m_count = m_period;
               else m_running = 0;
            end
         end
         m_flag = ev || (m_flag && !clr);
      end
      e.cnt   = m_count;
      e.pulse = ev;
      e.flag  = m_flag;
      e.busy  = m_running;
      e.id    = n_issued;
      n_issued++;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are presented every cycle; compare just after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (int'(counter_out) != e.cnt) begin
               n_err++;
               $display("FAIL counter_out vec %0d: got %0d expected %0d", e.id, counter_out, e.cnt);
            end
            if (zero_pulse !== e.pulse) begin
               n_err++;
               $display("FAIL zero_pulse vec %0d: got %b expected %b", e.id, zero_pulse, e.pulse);
            end
            if (underflow_out !== e.flag) begin
               n_err++;
               $display("FAIL underflow_out vec %0d: got %b expected %b", e.id, underflow_out, e.flag);
            end
            if (busy !== e.busy) begin
               n_err++;
               $display("FAIL busy vec %0d: got %b expected %b", e.id, busy, e.busy);
            end
         end
      end
   end

   initial begin
      int  wait_cyc;
      bit  ar;
      // reset
      step(0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0);
      // one-shot from 3
      step(0, 1, 3, 0, 0, 0);
      repeat (7) step(1, 0, 0, 0, 0, 0);
      // auto-reload from 2, nine enabled cycles
      step(0, 1, 2, 1, 0, 0);
      repeat (9) step(1, 0, 0, 1, 0, 0);
      // enable gating from 4
      step(0, 1, 4, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // load/underflow collision at count 0
      step(0, 1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 5, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      // sticky flag: clear alone, then clear with a coincident event
      step(0, 0, 0, 0, 1, 0);
      step(0, 1, 0, 1, 0, 0);
      step(1, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      // reset mid-run at count 4
      step(0, 1, 7, 0, 0, 0);
      repeat (3) step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      repeat (3) step(1, 0, 0, 0, 0, 0);
      // wide and edge load values
      step(0, 1, 15, 1, 0, 0);
      repeat (18) step(1, 0, 0, 1, 0, 0);
      // random traffic
      ar = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 31) == 0) ar = ~ar;
         step($urandom_range(0, 9) < 7,
              $urandom_range(0, 99) < 8,
              int'($urandom_range(0, 15)),
              ar,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 99) < 2);
      end
      wait_cyc = 0;
      while (exp_q.size() != 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
